// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one SDRAM/flash memory bus between two requesters: port 0 (N64 PI
// side) and port 1 (USB/PC bridge). Ownership is granted round-robin. It is
// held from the moment a request is taken until the memory acknowledges, or
// until a watchdog gives up on a hung transfer.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_reqN_*                requester N command (request/write/bank/address/data)
//   o_reqN_busy             low only in the cycle port N is taken (combinational)
//   o_reqN_ack/error/data   completion pulse, timeout flag, read data for port N
//   o_grant                 one-hot current owner, 0 when idle
//   o_request/o_write/o_bank_select/o_address/o_data   memory command
//   i_busy/i_ack/i_data     memory stall, completion pulse, read data
//
// Parameter
//   TIMEOUT_CYCLES          WAIT_ACK cycles tolerated before a forced
//                           completion with error (must be >= 1)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_req0_request,
    input  logic        i_req0_write,
    input  logic [3:0]  i_req0_bank,
    input  logic [27:0] i_req0_address,
    input  logic [31:0] i_req0_data,
    output logic        o_req0_busy,
    output logic        o_req0_ack,
    output logic        o_req0_error,
    output logic [31:0] o_req0_data,

    input  logic        i_req1_request,
    input  logic        i_req1_write,
    input  logic [3:0]  i_req1_bank,
    input  logic [27:0] i_req1_address,
    input  logic [31:0] i_req1_data,
    output logic        o_req1_busy,
    output logic        o_req1_ack,
    output logic        o_req1_error,
    output logic [31:0] o_req1_data,

    output logic [1:0]  o_grant,
    output logic [3:0]  o_bank_select,
    output logic        o_request,
    output logic        o_write,
    input  logic        i_busy,
    input  logic        i_ack,
    output logic [27:0] o_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic          last_q,    last_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          request_q, request_d;
    logic          write_q,   write_d;
    logic [3:0]    bank_q,    bank_d;
    logic [27:0]   addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;
    logic [1:0]    grant_q,   grant_d;
    logic [1:0]    ack_q,     ack_d;
    logic [1:0]    err_q,     err_d;
    logic [31:0]   rdata0_q,  rdata0_d;
    logic [31:0]   rdata1_q,  rdata1_d;

    logic sel_valid;
    logic sel_port;
    logic owner;
    logic done;
    logic timed_out;

    // Arbitration: a lone requester wins outright; on a tie the port that
    // was not served last wins. last_q resets to 1 so port 0 takes the
    // first tie after reset.
    always_comb begin
        sel_valid = (state_q == ST_IDLE) && (i_req0_request || i_req1_request);
        if (i_req0_request && i_req1_request) begin
            sel_port = ~last_q;
        end else begin
            sel_port = i_req1_request;
        end
    end

    // Busy is forced high during reset even though the state already reads
    // IDLE, so a requester never sees a phantom acceptance.
    assign o_req0_busy = !(i_reset_n && sel_valid && !sel_port);
    assign o_req1_busy = !(i_reset_n && sel_valid &&  sel_port);

    // The grant register doubles as the owner record while busy.
    assign owner = grant_q[1];

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        request_d = request_q;
        write_d   = write_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        done      = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (sel_port) begin
                        write_d = i_req1_write;
                        bank_d  = i_req1_bank;
                        addr_d  = i_req1_address;
                        wdata_d = i_req1_data;
                        grant_d = 2'b10;
                    end else begin
                        write_d = i_req0_write;
                        bank_d  = i_req0_bank;
                        addr_d  = i_req0_address;
                        wdata_d = i_req0_data;
                        grant_d = 2'b01;
                    end
                    request_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // An ack while the memory is still stalling is not ours.
                if (!i_busy) begin
                    request_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_WAIT;
                    done      = i_ack;
                end
            end

            ST_WAIT: begin
                // A real ack takes priority over the watchdog on the same cycle.
                if (i_ack) begin
                    done = 1'b1;
                end else if (timer_q == TIMEOUT_VAL) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            last_d  = owner;
            if (owner) begin
                ack_d    = 2'b10;
                err_d    = timed_out ? 2'b10 : 2'b00;
                rdata1_d = timed_out ? 32'h0 : i_data;
            end else begin
                ack_d    = 2'b01;
                err_d    = timed_out ? 2'b01 : 2'b00;
                rdata0_d = timed_out ? 32'h0 : i_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            timer_q   <= '0;
            request_q <= 1'b0;
            write_q   <= 1'b0;
            bank_q    <= 4'h0;
            addr_q    <= 28'h0;
            wdata_q   <= 32'h0;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            request_q <= request_d;
            write_q   <= write_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign o_request     = request_q;
    assign o_write       = write_q;
    assign o_bank_select = bank_q;
    assign o_address     = addr_q;
    assign o_data        = wdata_q;
    assign o_grant       = grant_q;

    assign o_req0_ack    = ack_q[0];
    assign o_req1_ack    = ack_q[1];
    assign o_req0_error  = err_q[0];
    assign o_req1_error  = err_q[1];
    assign o_req0_data   = rdata0_q;
    assign o_req1_data   = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// model (owner, memory-acceptance cycle, cycle arithmetic for the watchdog)
// predicts every output each cycle; a few literal expectations pin it.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  rq, wr;
    logic [3:0]  bk [2];
    logic [27:0] ad [2];
    logic [31:0] wd [2];
    logic        mbusy, mack;
    logic [31:0] mdin;

    logic        busy0, busy1, ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic [1:0]  grant;
    logic [3:0]  bsel;
    logic        mreq, mwr;
    logic [27:0] maddr;
    logic [31:0] mdout;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_req0_request (rq[0]),
        .i_req0_write   (wr[0]),
        .i_req0_bank    (bk[0]),
        .i_req0_address (ad[0]),
        .i_req0_data    (wd[0]),
        .o_req0_busy    (busy0),
        .o_req0_ack     (ack0),
        .o_req0_error   (err0),
        .o_req0_data    (rd0),
        .i_req1_request (rq[1]),
        .i_req1_write   (wr[1]),
        .i_req1_bank    (bk[1]),
        .i_req1_address (ad[1]),
        .i_req1_data    (wd[1]),
        .o_req1_busy    (busy1),
        .o_req1_ack     (ack1),
        .o_req1_error   (err1),
        .o_req1_data    (rd1),
        .o_grant        (grant),
        .o_bank_select  (bsel),
        .o_request      (mreq),
        .o_write        (mwr),
        .i_busy         (mbusy),
        .i_ack          (mack),
        .o_address      (maddr),
        .i_data         (mdin),
        .o_data         (mdout)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    int          cyc = 0;
    int          m_owner;      // -1 when nobody owns the bus
    bit          m_issued;     // memory has taken the command
    int          m_mcyc;       // cycle the memory took it
    bit          m_last;       // port served last
    logic [1:0]  acc;          // port taken in the current cycle
    logic        x_req, x_write;
    logic [1:0]  x_grant, x_ack, x_err;
    logic [3:0]  x_bank;
    logic [27:0] x_addr;
    logic [31:0] x_data;
    logic [31:0] x_rdata [2];

    task automatic model_reset();
        m_owner = -1; m_issued = 0; m_mcyc = 0; m_last = 1'b1;
        x_req = 0; x_write = 0; x_grant = 0; x_ack = 0; x_err = 0;
        x_bank = 0; x_addr = 0; x_data = 0; x_rdata[0] = 0; x_rdata[1] = 0;
    endtask

    task automatic finish_txn(input bit e);
        x_ack[m_owner]   = 1'b1;
        x_err[m_owner]   = e;
        x_rdata[m_owner] = e ? 32'h0 : mdin;
        m_last  = (m_owner == 1);
        x_grant = 2'b00;
        m_owner = -1;
    endtask

    // Called once per cycle at the falling edge: compare, then advance.
    task automatic model_cycle();
        int n;
        cyc++;
        if (!rst_n) model_reset();
        chk("o_request",     mreq,  x_req);
        chk("o_grant",       grant, x_grant);
        chk("o_write",       mwr,   x_write);
        chk("o_bank_select", bsel,  x_bank);
        chk("o_address",     maddr, x_addr);
        chk("o_data",        mdout, x_data);
        chk("o_req0_ack",    ack0,  x_ack[0]);
        chk("o_req1_ack",    ack1,  x_ack[1]);
        chk("o_req0_error",  err0,  x_err[0]);
        chk("o_req1_error",  err1,  x_err[1]);
        chk("o_req0_data",   rd0,   x_rdata[0]);
        chk("o_req1_data",   rd1,   x_rdata[1]);
        acc = 2'b00;
        if (rst_n && m_owner < 0) begin
            if (rq == 2'b11) acc[m_last ? 0 : 1] = 1'b1;
            else             acc = rq;
        end
        chk("o_req0_busy", busy0, !acc[0]);
        chk("o_req1_busy", busy1, !acc[1]);
        if (rst_n) begin
            x_ack = 0; x_err = 0;
            if (m_owner < 0) begin
                if (acc != 2'b00) begin
                    n = acc[1] ? 1 : 0;
                    m_owner = n; m_issued = 0;
                    x_req = 1'b1; x_grant = (n == 1) ? 2'b10 : 2'b01;
                    x_write = wr[n]; x_bank = bk[n]; x_addr = ad[n]; x_data = wd[n];
                end
            end else if (!m_issued) begin
                if (!mbusy) begin
                    m_issued = 1; m_mcyc = cyc; x_req = 1'b0;
                    if (mack) finish_txn(0);
                end
            end else if (mack) begin
                finish_txn(0);
            end else if (cyc - m_mcyc == TO + 1) begin
                finish_txn(1);
            end
        end
    endtask

    // One cycle: model at the falling edge, then return 2 time units after
    // the next rising edge, where new stimulus is applied.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int rem [2];
        int order [$];
        int hc;

        rst_n = 0; rq = 0; wr = 0; mbusy = 0; mack = 0; mdin = 0;
        for (int i = 0; i < 2; i++) begin bk[i] = 0; ad[i] = 0; wd[i] = 0; end
        model_reset();

        // Reset state
        tick(); tick();
        #1;
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_busy1", busy1, 1'b1);
        chk("rst_grant", grant, 2'b00);
        chk("rst_request", mreq, 1'b0);
        tick();
        rst_n = 1;

        // Round-robin: both ports, 4 writes each, zero-wait memory
        rq = 2'b11; wr = 2'b11;
        ad[0] = 28'h10; ad[1] = 28'h20; wd[0] = 32'hA000_0000; wd[1] = 32'hB000_0000;
        bk[0] = 4'h1; bk[1] = 4'h2;
        mbusy = 0; mack = 1;
        rem[0] = 4; rem[1] = 4;
        for (int c = 0; c < 40 && order.size() < 8; c++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    rem[n]--; wd[n] = wd[n] + 1;
                    if (rem[n] == 0) rq[n] = 1'b0;
                end
            end
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            mdin = $urandom;
        end
        chk("rr_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);
        mack = 0; rq = 0;
        tick(); tick();

        // Single read on port 0, ack 3 cycles after memory acceptance
        rq[0] = 1; wr[0] = 0; bk[0] = 4'h1; ad[0] = 28'h0000100; mdin = 32'h1111_1111;
        tick();                                   // cycle 1
        rq[0] = 0;
        #1;
        chk("A_request_c1", mreq, 1'b1);
        chk("A_grant_c1", grant, 2'b01);
        chk("A_address_c1", maddr, 28'h0000100);
        chk("A_bank_c1", bsel, 4'h1);
        tick();                                   // cycle 2
        #1;
        chk("A_request_c2", mreq, 1'b0);
        tick();                                   // cycle 3
        tick();                                   // cycle 4
        mack = 1; mdin = 32'hDEADBEEF;
        #1;
        chk("A_ack_c4", ack0, 1'b0);
        tick();                                   // cycle 5
        mack = 0; mdin = 32'h1234_5678;
        #1;
        chk("A_ack_c5", ack0, 1'b1);
        chk("A_data_c5", rd0, 32'hDEADBEEF);
        chk("A_ack1_c5", ack1, 1'b0);

        // Watchdog on port 1 with port 0 waiting behind it
        rq[1] = 1; wr[1] = 1; bk[1] = 4'h7; ad[1] = 28'h2468; wd[1] = 32'h55;
        tick();                                   // cycle 1
        rq[1] = 0;
        rq[0] = 1; wr[0] = 0; bk[0] = 4'h2; ad[0] = 28'h300;
        for (int c = 2; c <= 2 + TO + 1; c++) tick();
        #1;
        chk("B_ack1", ack1, 1'b1);
        chk("B_err1", err1, 1'b1);
        chk("B_data1", rd1, 32'h0);
        chk("B_busy0_taken", busy0, 1'b0);
        tick();                                   // port 0 cycle 1
        rq[0] = 0;
        #1;
        chk("B_grant0", grant, 2'b01);
        for (int c = 2; c <= 2 + TO; c++) tick(); // ack on the exact timeout cycle
        mack = 1; mdin = 32'hCAFEF00D;
        tick();
        mack = 0;
        #1;
        chk("B_ack0_edge", ack0, 1'b1);
        chk("B_err0_edge", err0, 1'b0);
        chk("B_data0_edge", rd0, 32'hCAFEF00D);

        // Memory stalls for 10 cycles during ISSUE
        rq[0] = 1; wr[0] = 1; bk[0] = 4'h3; ad[0] = 28'h400; wd[0] = 32'h77; mbusy = 1;
        tick();
        rq[0] = 0;
        #1;
        hc = mreq ? 1 : 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (c == 11) mbusy = 0;
            #1;
            if (mreq) hc++;
        end
        chk("C_request_cycles", hc, 11);
        mack = 1; mdin = 32'h0BAD_F00D;
        tick();
        mack = 0;
        #1;
        chk("C_ack0", ack0, 1'b1);

        // Reset during WAIT_ACK, then a stray ack in IDLE
        rq[1] = 1; wr[1] = 0; bk[1] = 4'h4; ad[1] = 28'h500;
        tick();
        rq[1] = 0;
        tick();
        tick();
        rst_n = 0; rq[0] = 1;
        #1;
        chk("D_grant_rst", grant, 2'b00);
        chk("D_request_rst", mreq, 1'b0);
        chk("D_busy0_rst", busy0, 1'b1);
        chk("D_busy1_rst", busy1, 1'b1);
        tick();
        tick();
        rst_n = 1; rq[0] = 0; mack = 1;
        tick();
        mack = 0;
        #1;
        chk("D_stray_ack0", ack0, 1'b0);
        chk("D_stray_ack1", ack1, 1'b0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 599) != 0);
            for (int n = 0; n < 2; n++) begin
                if (rq[n] && acc[n]) rq[n] = 1'b0;
                if (!rq[n] && $urandom_range(0, 2) == 0) begin
                    rq[n] = 1'b1;
                    wr[n] = 1'($urandom);
                    bk[n] = 4'($urandom);
                    ad[n] = 28'($urandom);
                    wd[n] = $urandom;
                end
            end
            mbusy = ($urandom_range(0, 2) == 0);
            mack  = ($urandom_range(0, 3) == 0);
            mdin  = $urandom;
        end
        rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
